// File: rtl/spindle_pkg.sv
// Shared constants, FSM state type and combinational IEEE-754 single add/mult cells
// for the spindle integrator.
package spindle_pkg;

    localparam logic [31:0] IEEE_0_5   = 32'h3F000000;
    localparam logic [31:0] IEEE_1     = 32'h3F800000;
    localparam logic [31:0] DEFAULT_DT = 32'h3A83126F;
    localparam logic [31:0] IEEE_QNAN  = 32'h7FC00000;

    typedef enum logic [1:0] {StIdle, StWait, StUpdate} state_e;

    // m: [26] hidden bit, [25:3] fraction, [2:0] guard/round/sticky; round to nearest even.
    // Subnormal results flush to signed zero.
    function automatic logic [31:0] fp_round_pack(input logic sign, input int exp,
                                                  input logic [26:0] m);
        logic [24:0] r;
        int          e;
        r = {1'b0, m[26:3]} + 25'(m[2] & (m[1] | m[0] | m[3]));
        e = exp;
        if (r[24]) begin
            r = r >> 1;
            e = e + 1;
        end
        if (e >= 255) return {sign, 8'hFF, 23'h0};
        if (e <= 0) return {sign, 31'h0};
        return {sign, e[7:0], r[22:0]};
    endfunction

    function automatic logic [31:0] fp_add(input logic [31:0] a, input logic [31:0] b);
        logic [31:0] big;
        logic [31:0] sml;
        logic [26:0] mb;
        logic [26:0] ms;
        logic [26:0] sh;
        logic [26:0] s27;
        logic [27:0] sum;
        int          d;
        int          e;
        if (a[30:23] == 8'hFF && a[22:0] != '0) return a;
        if (b[30:23] == 8'hFF && b[22:0] != '0) return b;
        if (a[30:23] == 8'hFF) begin
            if (b[30:23] == 8'hFF && a[31] != b[31]) return IEEE_QNAN;
            return a;
        end
        if (b[30:23] == 8'hFF) return b;
        if (a[30:23] == '0) return (b[30:23] == '0) ? {a[31] & b[31], 31'h0} : b;
        if (b[30:23] == '0) return a;
        if (a[30:0] >= b[30:0]) begin
            big = a;
            sml = b;
        end else begin
            big = b;
            sml = a;
        end
        d  = int'(big[30:23]) - int'(sml[30:23]);
        e  = int'(big[30:23]);
        mb = {1'b1, big[22:0], 3'b000};
        ms = {1'b1, sml[22:0], 3'b000};
        if (d > 26) begin
            sh = 27'h1;
        end else begin
            sh    = ms >> d;
            sh[0] = sh[0] | (|(ms & ((27'h1 << d) - 27'h1)));
        end
        if (big[31] == sml[31]) begin
            sum = {1'b0, mb} + {1'b0, sh};
            if (sum[27]) begin
                s27    = sum[27:1];
                s27[0] = s27[0] | sum[0];
                e      = e + 1;
            end else begin
                s27 = sum[26:0];
            end
        end else begin
            s27 = mb - sh;
            if (s27 == '0) return 32'h0;
            for (int i = 0; i < 26; i++) begin
                if (!s27[26]) begin
                    s27 = s27 << 1;
                    e   = e - 1;
                end
            end
        end
        return fp_round_pack(big[31], e, s27);
    endfunction

    function automatic logic [31:0] fp_mul(input logic [31:0] a, input logic [31:0] b);
        logic        s;
        logic [47:0] p;
        logic [26:0] m;
        int          e;
        s = a[31] ^ b[31];
        if (a[30:23] == 8'hFF && a[22:0] != '0) return a;
        if (b[30:23] == 8'hFF && b[22:0] != '0) return b;
        if (a[30:23] == 8'hFF) return (b[30:23] == '0) ? IEEE_QNAN : {s, 8'hFF, 23'h0};
        if (b[30:23] == 8'hFF) return (a[30:23] == '0) ? IEEE_QNAN : {s, 8'hFF, 23'h0};
        if (a[30:23] == '0 || b[30:23] == '0) return {s, 31'h0};
        p = 48'({1'b1, a[22:0]}) * 48'({1'b1, b[22:0]});
        e = int'(a[30:23]) + int'(b[30:23]) - 127;
        if (p[47]) begin
            m = {p[47:22], |p[21:0]};
            e = e + 1;
        end else begin
            m = {p[46:21], |p[20:0]};
        end
        return fp_round_pack(s, e, m);
    endfunction

endpackage

// File: rtl/spindle_tdm_integrator_if.sv
// Step and derivative handshakes of the spindle integrator. master = sequencer/derivative
// side, slave = integrator.
interface spindle_tdm_integrator_if #(
    parameter int unsigned NUM_CH = 3,
    parameter int unsigned NUM_ST = 3
);
    localparam int unsigned CH_W = (NUM_CH > 1) ? $clog2(NUM_CH) : 1;

    logic                   step_valid;
    logic                   step_ready;
    logic                   step_done;
    logic                   deriv_req_valid;
    logic [CH_W-1:0]        deriv_req_ch;
    logic [NUM_ST*32-1:0]   deriv_req_x;
    logic                   deriv_rsp_valid;
    logic [NUM_ST*32-1:0]   deriv_rsp_dx;

    modport master (
        output step_valid, deriv_rsp_valid, deriv_rsp_dx,
        input  step_ready, step_done, deriv_req_valid, deriv_req_ch, deriv_req_x
    );

    modport slave (
        input  step_valid, deriv_rsp_valid, deriv_rsp_dx,
        output step_ready, step_done, deriv_req_valid, deriv_req_ch, deriv_req_x
    );
endinterface

// File: rtl/spindle_state_update.sv
// One state lane update. SPINDLE_TRAP_EN selects trapezoidal integration,
// otherwise forward Euler (dx_prev unused).
module spindle_state_update
    import spindle_pkg::*;
#(
    parameter logic [31:0] DT = DEFAULT_DT
) (
    input  logic [31:0] x,
    input  logic [31:0] dx,
    input  logic [31:0] dx_prev,
    output logic [31:0] x_next
);
`ifdef SPINDLE_TRAP_EN
    always_comb x_next = fp_add(x, fp_mul(fp_mul(DT, IEEE_0_5), fp_add(dx, dx_prev)));
`else
    logic unused_dx_prev;
    assign unused_dx_prev = ^dx_prev;
    always_comb x_next = fp_add(x, fp_mul(DT, dx));
`endif
endmodule

// File: rtl/spindle_tdm_integrator.sv
// Time-multiplexed spindle state integrator: walks all channels once per step, requesting
// derivatives and writing back updated state. Optional trapezoidal mode: SPINDLE_TRAP_EN.
module spindle_tdm_integrator
    import spindle_pkg::*;
#(
    parameter int unsigned NUM_CH = 3,
    parameter int unsigned NUM_ST = 3,
    parameter logic [31:0] DT     = DEFAULT_DT,
    localparam int unsigned CH_W  = (NUM_CH > 1) ? $clog2(NUM_CH) : 1
) (
    input  logic                  clk,
    input  logic                  reset,
    spindle_tdm_integrator_if.slave bus,
    input  logic                  init_we,
    input  logic [CH_W-1:0]       init_ch,
    input  logic [NUM_ST*32-1:0]  init_x,
    input  logic [CH_W-1:0]       rd_ch,
    output logic [NUM_ST*32-1:0]  rd_x
);
    localparam int unsigned W = NUM_ST * 32;
    localparam logic [CH_W-1:0] LAST_CH = CH_W'(NUM_CH - 1);

    state_e          state_q;
    logic [CH_W-1:0] ch_q;
    logic            step_ready_q;
    logic            step_done_q;
    logic            req_valid_q;
    logic [W-1:0]    dx_q;
    logic [W-1:0]    x_q   [NUM_CH];
    logic [W-1:0]    dxp_q [NUM_CH];
    logic [W-1:0]    cur_x;
    logic [W-1:0]    cur_dxp;
    logic [W-1:0]    x_next;

    // ch_q never exceeds LAST_CH, so these reads are always in range.
    always_comb begin
        cur_x   = x_q[ch_q];
        cur_dxp = dxp_q[ch_q];
    end

    always_comb begin
        rd_x = '0;
        if (rd_ch <= LAST_CH) rd_x = x_q[rd_ch];
    end

    for (genvar i = 0; i < NUM_ST; i++) begin : g_lane
        spindle_state_update #(
            .DT(DT)
        ) u_lane (
            .x      (cur_x[32*i +: 32]),
            .dx     (dx_q[32*i +: 32]),
            .dx_prev(cur_dxp[32*i +: 32]),
            .x_next (x_next[32*i +: 32])
        );
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q      <= StIdle;
            ch_q         <= '0;
            step_ready_q <= 1'b1;
            step_done_q  <= 1'b0;
            req_valid_q  <= 1'b0;
            dx_q         <= '0;
            for (int unsigned c = 0; c < NUM_CH; c++) begin
                x_q[c]   <= '0;
                dxp_q[c] <= '0;
            end
        end else begin
            step_done_q <= 1'b0;
            unique case (state_q)
                StIdle: begin
                    // Init lands this edge, so a simultaneous step sees the new state.
                    if (init_we && (init_ch <= LAST_CH)) begin
                        x_q[init_ch]   <= init_x;
                        dxp_q[init_ch] <= '0;
                    end
                    if (bus.step_valid) begin
                        state_q      <= StWait;
                        ch_q         <= '0;
                        step_ready_q <= 1'b0;
                        req_valid_q  <= 1'b1;
                    end
                end
                StWait: begin
                    if (bus.deriv_rsp_valid) begin
                        dx_q        <= bus.deriv_rsp_dx;
                        req_valid_q <= 1'b0;
                        state_q     <= StUpdate;
                    end
                end
                StUpdate: begin
                    x_q[ch_q]   <= x_next;
                    dxp_q[ch_q] <= dx_q;
                    if (ch_q == LAST_CH) begin
                        state_q      <= StIdle;
                        step_done_q  <= 1'b1;
                        step_ready_q <= 1'b1;
                    end else begin
                        ch_q        <= ch_q + 1'b1;
                        req_valid_q <= 1'b1;
                        state_q     <= StWait;
                    end
                end
                default: state_q <= StIdle;
            endcase
        end
    end

    assign bus.step_ready      = step_ready_q;
    assign bus.step_done       = step_done_q;
    assign bus.deriv_req_valid = req_valid_q;
    assign bus.deriv_req_ch    = ch_q;
    assign bus.deriv_req_x     = cur_x;
endmodule
